// File: rtl/tdc_event_pkg.sv
// Shared definitions for the TDC event FIFO: register word offsets, entry layout, entry packing.
package tdc_event_pkg;

    // Word offsets, i.e. wb_adr_i[4:2]
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_TS     = 3'd1;
    localparam logic [2:0] REG_TAG    = 3'd2;
    localparam logic [2:0] REG_POP    = 3'd3;
    localparam logic [2:0] REG_DROPS  = 3'd4;
    localparam logic [2:0] REG_THRESH = 3'd5;

    localparam int CH_W     = 4;
    localparam int TS_MAX_W = 32;
    localparam int CH_LSB   = TS_MAX_W;
    localparam int POL_BIT  = TS_MAX_W + CH_W;

    // Timestamps are stored zero-extended to the widest supported width
    typedef struct packed {
        logic            pol;
        logic [CH_W-1:0] ch;
        logic [31:0]     ts;
    } entry_t;

    function automatic entry_t pack_entry(input logic pol, input logic [CH_W-1:0] ch,
                                          input logic [TS_MAX_W-1:0] ts);
        entry_t e;
        e.pol = pol;
        e.ch  = ch;
        e.ts  = ts;
        return e;
    endfunction

endpackage

// File: rtl/tdc_event_fifo_mem.sv
// Simple dual-port RAM, one write and one registered read port; read data one cycle after address.
// No backpressure; a read of the address being written returns the old contents.
module tdc_event_fifo_mem #(
    parameter int g_WIDTH      = 37,
    parameter int g_DEPTH_LOG2 = 9
) (
    input  logic                    sys_clk,
    input  logic                    wr_en,
    input  logic [g_DEPTH_LOG2-1:0] wr_addr,
    input  logic [g_WIDTH-1:0]      wr_dat,
    input  logic [g_DEPTH_LOG2-1:0] rd_addr,
    output logic [g_WIDTH-1:0]      rd_dat
);

    logic [g_WIDTH-1:0] mem [1 << g_DEPTH_LOG2];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/tdc_event_fifo.sv
// TDC event capture, round-robin merge into a show-ahead FIFO, Wishbone readout; detect to level visible 2 cycles.
// A full FIFO stalls the holding registers; further events on a busy channel are dropped and counted.
module tdc_event_fifo
    import tdc_event_pkg::*;
#(
    parameter int g_CHANNEL_COUNT = 2,
    parameter int g_TS_WIDTH      = 32,
    parameter int g_DEPTH_LOG2    = 9
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst,
    input  logic [g_CHANNEL_COUNT-1:0]          detect_i,
    input  logic [g_CHANNEL_COUNT-1:0]          polarity_i,
    input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] ts_i,
    input  logic [31:0]                         wb_adr_i,
    input  logic [31:0]                         wb_dat_i,
    output logic [31:0]                         wb_dat_o,
    input  logic [3:0]                          wb_sel_i,
    input  logic                                wb_cyc_i,
    input  logic                                wb_stb_i,
    input  logic                                wb_we_i,
    output logic                                wb_ack_o,
    output logic                                irq_o
);

    localparam int LVL_W = g_DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]        LVL_FULL = {1'b1, {g_DEPTH_LOG2{1'b0}}};
    localparam logic [LVL_W-1:0]        LVL_ONE  = LVL_W'(1);
    localparam logic [g_DEPTH_LOG2-1:0] PTR_ONE  = g_DEPTH_LOG2'(1);

    logic [g_CHANNEL_COUNT-1:0] hold_vld;
    logic [g_CHANNEL_COUNT-1:0] hold_pol;
    logic [g_TS_WIDTH-1:0]      hold_ts [g_CHANNEL_COUNT];
    logic [g_CHANNEL_COUNT-1:0] drain;
    logic [g_CHANNEL_COUNT-1:0] drop;
    logic [4:0]                 drop_cnt;

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] grant_ch;
    logic            grant_vld;

    logic [g_DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_addr;
    logic [LVL_W-1:0]        level;
    logic                    empty, full, push, pop;
    entry_t                  push_dat, ram_dat, byp_dat, head;
    logic                    byp_vld;

    logic [31:0] drops;
    logic [32:0] drops_sum;
    logic [15:0] thresh;

    logic        wb_req, pop_req, drops_clr, thresh_wr;
    logic [2:0]  wb_word;
    logic [31:0] rd_mux;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16]};

    // Round-robin search from rr_ptr; nothing is granted while the FIFO is full
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < g_CHANNEL_COUNT; i++) begin
            if (!grant_vld && !full && hold_vld[(int'(rr_ptr) + i) % g_CHANNEL_COUNT]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'((int'(rr_ptr) + i) % g_CHANNEL_COUNT);
            end
        end
    end

    // A slot being drained this cycle may be reloaded without counting a drop
    always_comb begin
        drain    = '0;
        drop     = '0;
        drop_cnt = '0;
        for (int c = 0; c < g_CHANNEL_COUNT; c++) begin
            drain[c] = grant_vld && (grant_ch == CH_W'(c));
            drop[c]  = detect_i[c] && hold_vld[c] && !drain[c];
            drop_cnt = drop_cnt + 5'(drop[c]);
        end
    end

    assign push_dat  = pack_entry(hold_pol[grant_ch], grant_ch, 32'(hold_ts[grant_ch]));
    assign push      = grant_vld;
    assign empty     = (level == '0);
    assign full      = (level == LVL_FULL);
    assign drops_sum = {1'b0, drops} + 33'(drop_cnt);

    assign wb_req    = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wb_word   = wb_adr_i[4:2];
    assign pop_req   = wb_req && wb_we_i && (wb_word == REG_POP);
    assign drops_clr = wb_req && wb_we_i && (wb_word == REG_DROPS);
    assign thresh_wr = wb_req && wb_we_i && (wb_word == REG_THRESH);
    assign pop       = pop_req && !empty;

    // Prefetch the entry that will be head after this edge
    assign rd_addr = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign head    = byp_vld ? byp_dat : ram_dat;

    tdc_event_fifo_mem #(
        .g_WIDTH      ($bits(entry_t)),
        .g_DEPTH_LOG2 (g_DEPTH_LOG2)
    ) u_mem (
        .sys_clk (sys_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_dat  (push_dat),
        .rd_addr (rd_addr),
        .rd_dat  (ram_dat)
    );

    always_comb begin
        rd_mux = '0;
        case (wb_word)
            REG_STATUS: rd_mux = {14'd0, full, empty, 16'(level)};
            REG_TS:     rd_mux = empty ? 32'd0 : head.ts;
            REG_TAG:    rd_mux = empty ? 32'd0 : {23'd0, head.pol, 4'd0, head.ch};
            REG_DROPS:  rd_mux = drops;
            REG_THRESH: rd_mux = {16'd0, thresh};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_vld <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            byp_vld  <= 1'b0;
            drops    <= '0;
            thresh   <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            for (int c = 0; c < g_CHANNEL_COUNT; c++) begin
                if (drain[c]) begin
                    hold_vld[c] <= 1'b0;
                end
                if (detect_i[c] && !drop[c]) begin
                    hold_vld[c] <= 1'b1;
                    hold_pol[c] <= polarity_i[c];
                    hold_ts[c]  <= ts_i[c*g_TS_WIDTH +: g_TS_WIDTH];
                end
            end

            if (grant_vld) begin
                rr_ptr <= (int'(grant_ch) + 1 >= g_CHANNEL_COUNT) ? '0 : grant_ch + CH_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase

            // RAM returns stale data when the prefetch address is written this edge
            byp_vld <= push && (wr_ptr == rd_addr);
            byp_dat <= push_dat;

            if (drops_clr) begin
                drops <= '0;
            end else if (drop_cnt != '0) begin
                drops <= drops_sum[32] ? '1 : drops_sum[31:0];
            end

            if (thresh_wr) begin
                thresh <= wb_dat_i[15:0];
            end

            wb_ack_o <= wb_req;
            wb_dat_o <= wb_req ? rd_mux : 32'd0;
            irq_o    <= (thresh != 16'd0) && (16'(level) >= thresh);
        end
    end

endmodule

// File: tb/tb_tdc_event_fifo.sv
// Directed bench for tdc_event_fifo: register table plus fill, interrupt, drop and reset sequences.
module tb_tdc_event_fifo;

    localparam logic [31:0] A_STATUS = 32'hC000_0000;
    localparam logic [31:0] A_TS     = 32'hC000_0004;
    localparam logic [31:0] A_TAG    = 32'hC000_0008;
    localparam logic [31:0] A_POP    = 32'hC000_000C;
    localparam logic [31:0] A_DROPS  = 32'hC000_0010;
    localparam logic [31:0] A_THRESH = 32'hC000_0014;

    localparam int K_EVT = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int          kind;
        logic [1:0]  det;
        logic [1:0]  pol;
        logic [31:0] ts0;
        logic [31:0] ts1;
        logic [31:0] adr;
        logic [31:0] dat;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  detect_i, polarity_i;
    logic [63:0] ts_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, irq_o;

    int total = 0;
    int bad   = 0;

    tdc_event_fifo dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .detect_i   (detect_i),
        .polarity_i (polarity_i),
        .ts_i       (ts_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_ack_o   (wb_ack_o),
        .irq_o      (irq_o)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, required to finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] det, input logic [1:0] pol,
                         input logic [31:0] t0, input logic [31:0] t1);
        detect_i   = det;
        polarity_i = pol;
        ts_i       = {t1, t0};
        tick(1);
        detect_i   = 2'b00;
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] rdat);
        bit got;
        got      = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wdat;
        for (int n = 0; n < 8; n++) begin
            tick(1);
            if (wb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        rdat     = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wb_ack_timeout adr=0x%08h: ack=0 after 8 cycles, ack=1 required", adr);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(1'b0, adr, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic double_hit();
        // Both channels fire on two consecutive edges: one slot is drained, the other drops once
        detect_i   = 2'b11;
        polarity_i = 2'b00;
        ts_i       = {32'h77, 32'h66};
        tick(2);
        detect_i   = 2'b00;
    endtask

    function automatic vec_t mk(input int k, input logic [1:0] d, input logic [1:0] p,
                                input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] a, input logic [31:0] v);
        vec_t r;
        r.kind = k; r.det = d; r.pol = p; r.ts0 = t0; r.ts1 = t1; r.adr = a; r.dat = v;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        int          errs;

        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0001_0000));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_DROPS, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_THRESH, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, 32'hC000_0018, 32'h0));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_THRESH, 32'hABCD_1234));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_THRESH, 32'h0000_1234));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_THRESH, 32'h0));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, 32'hC000_001C, 32'hFFFF_FFFF));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, 32'hC000_001C, 32'h0));
        vecs.push_back(mk(K_EVT, 2'b01, 2'b01, 32'h1234, 0, 0, 0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0000_0001));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h1234));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h100));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0001_0000));
        vecs.push_back(mk(K_EVT, 2'b10, 2'b00, 0, 32'h7, 0, 0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h7));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h001));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_EVT, 2'b11, 2'b01, 32'h5, 32'h9, 0, 0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h5));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h100));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0000_0002));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h9));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h001));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_EVT, 2'b01, 2'b00, 32'hAA, 0, 0, 0));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_EVT, 2'b11, 2'b10, 32'h11, 32'h22, 0, 0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h22));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h101));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TS, 32'h11));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_TAG, 32'h000));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0001_0000));
        vecs.push_back(mk(K_WR,  2'b00, 2'b00, 0, 0, A_POP, 32'h0));
        vecs.push_back(mk(K_RD,  2'b00, 2'b00, 0, 0, A_STATUS, 32'h0001_0000));

        sys_rst    = 1'b1;
        detect_i   = 2'b00;
        polarity_i = 2'b00;
        ts_i       = 64'd0;
        wb_adr_i   = 32'd0;
        wb_dat_i   = 32'd0;
        wb_sel_i   = 4'hF;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        wb_we_i    = 1'b0;
        tick(3);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        sys_rst = 1'b0;
        tick(1);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                K_EVT: begin
                    pulse(vecs[i].det, vecs[i].pol, vecs[i].ts0, vecs[i].ts1);
                    tick(1);
                end
                K_WR: wb_write(vecs[i].adr, vecs[i].dat);
                default: wb_check($sformatf("vec%0d_rd_%02h", i, vecs[i].adr[7:0]),
                                  vecs[i].adr, vecs[i].dat);
            endcase
        end

        // Detect sampled at one edge, pushed at the next: a read sampled there still sees empty
        pulse(2'b01, 2'b01, 32'h55, 32'h0);
        wb_check("latency_early", A_STATUS, 32'h0001_0000);
        wb_check("latency_visible", A_STATUS, 32'h0000_0001);
        wb_write(A_POP, 32'h0);
        tick(1);
        check("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);

        // Fill: 515 back-to-back events, 512 stored, 1 held, 2 dropped
        for (int i = 0; i < 515; i++) begin
            detect_i   = 2'b01;
            polarity_i = 2'b00;
            ts_i       = {32'd0, 32'(i)};
            tick(1);
        end
        detect_i = 2'b00;
        tick(3);
        wb_check("fill_status", A_STATUS, 32'h0002_0200);
        wb_check("fill_drops", A_DROPS, 32'd2);
        wb_check("fill_head_ts", A_TS, 32'd0);
        check("irq_thresh0_full", {31'd0, irq_o}, 32'd0);
        wb_write(A_POP, 32'h0);
        wb_check("refill_status", A_STATUS, 32'h0002_0200);
        wb_check("refill_head_ts", A_TS, 32'd1);

        errs = 0;
        for (int i = 0; i < 512; i++) begin
            wb_access(1'b0, A_TS, 32'd0, rd);
            if (rd !== 32'(i + 1)) errs++;
            wb_write(A_POP, 32'h0);
        end
        check("drain_order_errors", 32'(errs), 32'd0);
        wb_check("drain_status", A_STATUS, 32'h0001_0000);

        // Threshold interrupt
        wb_write(A_THRESH, 32'd3);
        pulse(2'b01, 2'b00, 32'h1, 32'h0);
        tick(1);
        pulse(2'b01, 2'b00, 32'h2, 32'h0);
        tick(3);
        check("irq_level2", {31'd0, irq_o}, 32'd0);
        pulse(2'b01, 2'b00, 32'h3, 32'h0);
        tick(1);
        check("irq_level3_not_yet", {31'd0, irq_o}, 32'd0);
        tick(1);
        check("irq_level3", {31'd0, irq_o}, 32'd1);
        wb_write(A_POP, 32'h0);
        check("irq_after_pop_edge", {31'd0, irq_o}, 32'd1);
        tick(1);
        check("irq_after_pop", {31'd0, irq_o}, 32'd0);

        // Level 5, then push and pop land on the same edge
        for (int i = 0; i < 3; i++) begin
            pulse(2'b01, 2'b00, 32'(16 + i), 32'h0);
            tick(1);
        end
        tick(2);
        wb_check("level5", A_STATUS, 32'h0000_0005);
        pulse(2'b01, 2'b00, 32'h20, 32'h0);
        wb_write(A_POP, 32'h0);
        wb_check("push_pop_same_edge", A_STATUS, 32'h0000_0005);

        // Drop counting and clear-vs-increment
        wb_write(A_DROPS, 32'hFFFF_FFFF);
        wb_check("drops_cleared", A_DROPS, 32'd0);
        double_hit();
        tick(3);
        wb_check("drops_one", A_DROPS, 32'd1);
        detect_i   = 2'b11;
        polarity_i = 2'b00;
        tick(1);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = A_DROPS;
        wb_dat_i = 32'd0;
        tick(1);
        detect_i = 2'b00;
        check("drops_clr_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        tick(2);
        wb_check("drops_clear_wins", A_DROPS, 32'd0);

        // Reset mid-traffic at level 7 with irq set and a nonzero drop count
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        wb_write(A_THRESH, 32'd1);
        double_hit();
        tick(3);
        for (int i = 0; i < 4; i++) begin
            pulse(2'b01, 2'b01, 32'(100 + i), 32'h0);
            tick(1);
        end
        tick(2);
        wb_check("pre_rst_level7", A_STATUS, 32'h0000_0007);
        wb_check("pre_rst_drops", A_DROPS, 32'd1);
        check("pre_rst_irq", {31'd0, irq_o}, 32'd1);

        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = A_STATUS;
        errs = 1;
        for (int n = 0; n < 8; n++) begin
            tick(1);
            if (wb_ack_o) begin
                errs = 0;
                break;
            end
        end
        check("rst_ack_seen", 32'(errs), 32'd0);
        check("rst_ack_dat", wb_dat_o, 32'h0000_0007);
        sys_rst = 1'b1;
        tick(1);
        check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_mid_irq", {31'd0, irq_o}, 32'd0);
        check("rst_mid_dat", wb_dat_o, 32'd0);
        tick(1);
        check("rst_held_ack", {31'd0, wb_ack_o}, 32'd0);
        sys_rst  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick(2);
        wb_check("post_rst_status", A_STATUS, 32'h0001_0000);
        wb_check("post_rst_drops", A_DROPS, 32'd0);
        wb_check("post_rst_thresh", A_THRESH, 32'd0);
        check("post_rst_irq", {31'd0, irq_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdc_event_fifo.md
Name: tdc_event_fifo

Overview:
- Wishbone slave that buffers TDC detection events and lets the CPU drain them.
- Sits directly downstream of the TDC core. It takes per-channel detect pulses, polarity and timestamps, and merges them into one event FIFO.
- The CPU reads the FIFO over a free conbus slot at 0xc0000000.
- Raises a level-threshold interrupt and counts events dropped on overflow.

Parameters:
- g_CHANNEL_COUNT, 2: number of TDC channels (1..16).
- g_TS_WIDTH, 32: timestamp width in bits (1..32).
- g_DEPTH_LOG2, 9: log2 of FIFO depth (512 entries).

Ports:
- sys_clk  in  1  system clock; all logic is on this clock.
- sys_rst  in  1  reset, synchronous, active-high.
- detect_i  in  g_CHANNEL_COUNT  one-cycle event strobe per channel.
- polarity_i  in  g_CHANNEL_COUNT  edge polarity per channel; 1 = rising. Valid with detect_i.
- ts_i  in  g_CHANNEL_COUNT*g_TS_WIDTH  packed timestamps, channel 0 in the LSBs. Valid with detect_i.
- wb_adr_i  in  32  byte address; only bits [4:2] are decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte selects; ignored, all accesses are treated as 32-bit.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  interrupt, level-sensitive.

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, FIFO empty (level 0), DROPS=0, THRESH=0, all holding registers invalid, round-robin pointer=0.
- Capture stage: one 1-deep holding register per channel, storing {pol, ts} plus a valid bit.
  - detect_i[c] loads it and sets valid.
  - If valid is already set and that slot is not being drained this cycle, the new event is dropped and DROPS increments (saturates at 0xFFFFFFFF).
  - A slot drained this cycle may be reloaded in the same cycle; this is not a drop.
- Merge: round-robin arbiter over valid slots, at most one FIFO write per cycle.
  - Search starts at pointer p; after a grant to channel g, p becomes g+1 mod g_CHANNEL_COUNT.
  - A grant happens only if the FIFO is not full. A full FIFO stalls the slots, and drops then occur at the capture stage.
- Latency: detect_i in cycle N; earliest FIFO write at edge N+1; level visible in STATUS from cycle N+2.
- FIFO entry: {pol(1), ch(4), ts(g_TS_WIDTH)}.
  - Synchronous-read RAM with a registered head (show-ahead): the head is valid whenever level>0.
  - Pointers are g_DEPTH_LOG2 bits and wrap naturally.
  - Level counter is g_DEPTH_LOG2+1 bits, so a full FIFO reads as exactly 2^g_DEPTH_LOG2.
- Simultaneous push and pop: level unchanged, both pointers advance. Pop when empty is ignored.
- Register map, offset -> function:
  - 0x00 STATUS (RO): [15:0] level, [16] empty, [17] full.
  - 0x04 TS (RO): head timestamp, zero-extended. Reads 0 when empty.
  - 0x08 TAG (RO): [3:0] head ch, [8] head pol. Reads 0 when empty.
  - 0x0C POP (WO): any write pops one entry.
  - 0x10 DROPS (RW): read returns the count; any write clears it. A clear wins over a simultaneous increment.
  - 0x14 THRESH (RW): [15:0] threshold.
  - Other offsets read 0; writes to them are ignored.
- Wishbone handshake:
  - wb_ack_o rises the cycle after (cyc & stb & ~ack) and is high for exactly one cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - wb_dat_o is registered and valid while ack=1.
  - The side effect (pop, clear, write) occurs on the edge at which ack rises.
- irq_o: registered; equals (THRESH!=0) & (level >= THRESH). It deasserts the cycle after level drops below THRESH.
- sys_rst asserted mid-operation: FIFO, holding registers and DROPS are cleared on that edge, and any in-flight ack is suppressed (ack=0 next cycle).

Decomposition:
- Package tdc_event_pkg holds:
  - register offset constants (REG_STATUS..REG_THRESH);
  - the entry-field widths and bit positions (CH_W=4, POL_BIT);
  - a function packing {pol, ch, ts}.
- One natural sub-module: tdc_event_fifo_mem, a simple dual-port synchronous RAM (one write port, one read port) parameterised by width and depth, so it infers block RAM.
- The arbiter, holding registers and Wishbone decode stay in the top module.

Test Plan:
- Single event: detect_i=01, ts=0x1234, pol=1 -> STATUS level=1 two cycles later; TS=0x1234; TAG=0x100; write POP -> STATUS=0x10000 (empty).
- Simultaneous channels: detect_i=11 with ts0=5, ts1=9 -> two entries, ch0 then ch1. Repeat with p=1 -> ch1 first.
- Fill: 512 single-channel events, then 3 more -> STATUS=0x20200. The first extra event waits in its holding register; the next two are dropped, so DROPS=2. Pop once -> the held event enters, level stays 512.
- Interrupt: THRESH=3; push 2 -> irq_o=0; push 3rd -> irq_o=1; pop -> irq_o=0. THRESH=0 with full FIFO -> irq_o=0.
- Same-cycle push and pop at level 5 -> level stays 5. DROPS write concurrent with a drop -> DROPS=0.
- Reset mid-traffic: assert sys_rst during an ack cycle with level 7 -> next cycle level=0, ack=0, irq_o=0, DROPS=0.
